// File: rtl/ball_pkg.sv
// Shared encodings for the ball state machine and its downstream consumers.
package ball_pkg;

  localparam logic [1:0] BALL_AIR = 2'd0;
  localparam logic [1:0] BALL_G1  = 2'd1;
  localparam logic [1:0] BALL_G2  = 2'd2;

  localparam int BALL_RADIUS_MM = 50;

  typedef enum logic [1:0] {
    GS_IDLE    = 2'd0,
    GS_HELD    = 2'd1,
    GS_FLIGHT  = 2'd2,
    GS_DROPPED = 2'd3
  } game_state_t;

  // Encoding 3 is not a legal ball position; treat it as airborne.
  function automatic logic [1:0] ball_norm(input logic [1:0] b);
    return (b == 2'd3) ? BALL_AIR : b;
  endfunction

  function automatic logic is_glove(input logic [1:0] b);
    return (b == BALL_G1) || (b == BALL_G2);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running tick divider: one-cycle pulse every CLKS_PER_TICK clocks.
module tick_gen #(
  parameter int CLKS_PER_TICK = 210938
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt_q;

  // Counter starts at terminal count, so the first tick lands right after reset.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (cnt_q == '0)
      cnt_q <= RELOAD;
    else
      cnt_q <= cnt_q - CW'(1);
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/catch_scorer.sv
// Rally tracker behind the ball state machine: pass score, streaks, drop detection.
//   state      | meaning
//   GS_IDLE    | no glove holds the ball, waiting for one to pick it up
//   GS_HELD    | a glove (holder) has the ball
//   GS_FLIGHT  | ball thrown by thrower, counting flight ticks
//   GS_DROPPED | ball hit floor or timed out, holding before IDLE
module catch_scorer
  import ball_pkg::*;
#(
  parameter int CLKS_PER_TICK  = 210938,
  parameter int FLOOR_MM       = BALL_RADIUS_MM + 5,
  parameter int FLIGHT_TIMEOUT = 640,
  parameter int DROP_HOLD      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ball_state,
  input  logic [15:0] ball_y,
  input  logic        catch_event,
  input  logic        throw_event,
  output logic [1:0]  game_state,
  output logic [15:0] score,
  output logic [7:0]  streak,
  output logic [7:0]  best_streak,
  output logic [9:0]  flight_ticks,
  output logic        pass_event,
  output logic        drop_event
);

  localparam int HW = (DROP_HOLD > 1) ? $clog2(DROP_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(DROP_HOLD - 1);
  localparam logic [15:0]   FLOOR_Y     = 16'(FLOOR_MM);
  localparam logic [9:0]    FT_LAST     = 10'(FLIGHT_TIMEOUT - 1);

  logic          tick;
  logic [1:0]    bs;
  logic          glove;
  logic          floor_hit;
  logic [7:0]    streak_inc;
  logic [15:0]   score_inc;

  game_state_t   state_q;
  logic [1:0]    holder_q;
  logic [1:0]    thrower_q;
  logic [HW-1:0] hold_q;
  logic [15:0]   score_q;
  logic [7:0]    streak_q;
  logic [7:0]    best_q;
  logic [9:0]    ft_q;
  logic          pass_q;
  logic          drop_q;

  tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign bs         = ball_norm(ball_state);
  assign glove      = is_glove(bs);
  assign floor_hit  = (ball_y < FLOOR_Y);
  assign streak_inc = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
  assign score_inc  = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= GS_IDLE;
      holder_q  <= BALL_AIR;
      thrower_q <= BALL_AIR;
      hold_q    <= '0;
      score_q   <= '0;
      streak_q  <= '0;
      best_q    <= '0;
      ft_q      <= '0;
      pass_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      pass_q <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        GS_IDLE: begin
          if (glove) begin
            state_q  <= GS_HELD;
            holder_q <= bs;
          end
        end
        GS_HELD: begin
          if (throw_event) begin
            state_q   <= GS_FLIGHT;
            thrower_q <= holder_q;
            ft_q      <= '0;
          end else if (glove && bs != holder_q) begin
            holder_q <= bs;
          end
        end
        GS_FLIGHT: begin
          if (catch_event && glove) begin
            state_q  <= GS_HELD;
            holder_q <= bs;
            if (bs != thrower_q) begin
              score_q  <= score_inc;
              streak_q <= streak_inc;
              if (streak_inc > best_q) best_q <= streak_inc;
              pass_q   <= 1'b1;
            end
          end else if (glove) begin
            // Respawn at a glove without a catch breaks the rally.
            state_q  <= GS_HELD;
            holder_q <= bs;
            streak_q <= '0;
          end else if (floor_hit || (tick && ft_q == FT_LAST)) begin
            state_q  <= GS_DROPPED;
            hold_q   <= HOLD_RELOAD;
            streak_q <= '0;
            drop_q   <= 1'b1;
            if (!floor_hit) ft_q <= ft_q + 10'd1;
          end else if (tick) begin
            ft_q <= ft_q + 10'd1;
          end
        end
        GS_DROPPED: begin
          if (glove) begin
            state_q  <= GS_HELD;
            holder_q <= bs;
            hold_q   <= HOLD_RELOAD;
          end else if (tick) begin
            if (hold_q == '0)
              state_q <= GS_IDLE;
            else
              hold_q <= hold_q - HW'(1);
          end
        end
      endcase
    end
  end

  assign game_state   = state_q;
  assign score        = score_q;
  assign streak       = streak_q;
  assign best_streak  = best_q;
  assign flight_ticks = ft_q;
  assign pass_event   = pass_q;
  assign drop_event   = drop_q;

endmodule

// File: tb/tb_catch_scorer.sv
// Scoreboard bench for catch_scorer with a short tick period and small timeouts.
module tb_catch_scorer;

  localparam int CPT = 4;
  localparam int FT  = 8;
  localparam int DH  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ball_state;
  logic [15:0] ball_y;
  logic        catch_event;
  logic        throw_event;
  logic [1:0]  game_state;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [7:0]  best_streak;
  logic [9:0]  flight_ticks;
  logic        pass_event;
  logic        drop_event;

  always #5 clk = ~clk;

  catch_scorer #(
    .CLKS_PER_TICK (CPT),
    .FLOOR_MM      (55),
    .FLIGHT_TIMEOUT(FT),
    .DROP_HOLD     (DH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ball_state   (ball_state),
    .ball_y       (ball_y),
    .catch_event  (catch_event),
    .throw_event  (throw_event),
    .game_state   (game_state),
    .score        (score),
    .streak       (streak),
    .best_streak  (best_streak),
    .flight_ticks (flight_ticks),
    .pass_event   (pass_event),
    .drop_event   (drop_event)
  );

  typedef struct {
    logic [1:0]  gs;
    logic [15:0] sc;
    logic [7:0]  st;
    logic [7:0]  bst;
    logic [9:0]  ft;
    logic        pe;
    logic        de;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  int          m_cyc;
  logic [1:0]  m_state, m_holder, m_thrower;
  logic [15:0] m_score;
  logic [7:0]  m_streak, m_best;
  logic [9:0]  m_ft;
  int          m_hold;
  logic        m_pass, m_drop;
  logic        last_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_state = 2'd0; m_holder = 2'd0; m_thrower = 2'd0;
    m_score = '0; m_streak = '0; m_best = '0; m_ft = '0; m_hold = 0;
    m_pass = 1'b0; m_drop = 1'b0; last_tick = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] bsi, input logic [15:0] y,
                            input logic c, input logic t);
    logic [1:0] b;
    logic       g;
    m_cyc++;
    last_tick = (((m_cyc - 1) % CPT) == 0);
    b = (bsi == 2'd3) ? 2'd0 : bsi;
    g = (b == 2'd1) || (b == 2'd2);
    m_pass = 1'b0;
    m_drop = 1'b0;
    case (m_state)
      2'd0: if (g) begin m_state = 2'd1; m_holder = b; end
      2'd1: begin
        if (t) begin m_state = 2'd2; m_thrower = m_holder; m_ft = '0; end
        else if (g && b != m_holder) m_holder = b;
      end
      2'd2: begin
        if (c && g) begin
          m_state = 2'd1; m_holder = b;
          if (b != m_thrower) begin
            if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
            if (m_streak != 8'hFF) m_streak = m_streak + 8'd1;
            if (m_streak > m_best) m_best = m_streak;
            m_pass = 1'b1;
          end
        end else if (g) begin
          m_state = 2'd1; m_holder = b; m_streak = '0;
        end else if (y < 16'd55) begin
          m_state = 2'd3; m_drop = 1'b1; m_streak = '0; m_hold = 0;
        end else if (last_tick && m_ft == 10'(FT - 1)) begin
          m_state = 2'd3; m_drop = 1'b1; m_streak = '0; m_hold = 0; m_ft = 10'(FT);
        end else if (last_tick) begin
          m_ft = m_ft + 10'd1;
        end
      end
      default: begin
        if (g) begin m_state = 2'd1; m_holder = b; m_hold = 0; end
        else if (last_tick) begin
          m_hold++;
          if (m_hold == DH) begin m_state = 2'd0; m_hold = 0; end
        end
      end
    endcase
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("game_state",   32'(game_state),   32'(e.gs));
      chk("score",        32'(score),        32'(e.sc));
      chk("streak",       32'(streak),       32'(e.st));
      chk("best_streak",  32'(best_streak),  32'(e.bst));
      chk("flight_ticks", 32'(flight_ticks), 32'(e.ft));
      chk("pass_event",   32'(pass_event),   32'(e.pe));
      chk("drop_event",   32'(drop_event),   32'(e.de));
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.gs = m_state; e.sc = m_score; e.st = m_streak; e.bst = m_best;
    e.ft = m_ft; e.pe = m_pass; e.de = m_drop;
    return e;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [1:0] bsi, input logic [15:0] y,
                      input logic c, input logic t);
    ball_state = bsi; ball_y = y; catch_event = c; throw_event = t;
    model_step(bsi, y, c, t);
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    compare();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ball_state = 2'd0; ball_y = 16'd1000; catch_event = 1'b0; throw_event = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    compare();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pass_to(input logic [1:0] to);
    step(2'd0, 16'd1000, 1'b0, 1'b1);
    step(to,   16'd1000, 1'b1, 1'b0);
  endtask

  initial begin
    int   ticks, ticks_at_drop;
    logic seen;
    logic [9:0] prev_ft, ft_before;

    reset = 1'b1;
    ball_state = 2'd0; ball_y = 16'd1000; catch_event = 1'b0; throw_event = 1'b0;
    @(negedge clk);
    do_reset();

    // ignored events in IDLE, then pass g1 -> g2
    step(2'd0, 16'd1000, 1'b1, 1'b1);
    step(2'd1, 16'd1000, 1'b0, 1'b0);
    step(2'd1, 16'd1000, 1'b1, 1'b0);
    pass_to(2'd2);
    chk("p1_pass",  32'(pass_event), 32'd1);
    chk("p1_score", 32'(score), 32'd1);
    chk("p1_best",  32'(best_streak), 32'd1);
    chk("p1_state", 32'(game_state), 32'd1);

    // pass back, then self catch by g1
    pass_to(2'd1);
    step(2'd0, 16'd1000, 1'b0, 1'b1);
    step(2'd0, 16'd1000, 1'b0, 1'b0);
    step(2'd1, 16'd1000, 1'b1, 1'b0);
    chk("self_pass",   32'(pass_event), 32'd0);
    chk("self_score",  32'(score), 32'd2);
    chk("self_streak", 32'(streak), 32'd2);

    // third pass, then floor drop
    pass_to(2'd2);
    step(2'd0, 16'd1000, 1'b0, 1'b1);
    step(2'd0, 16'd54,   1'b0, 1'b0);
    chk("floor_drop",   32'(drop_event), 32'd1);
    chk("floor_streak", 32'(streak), 32'd0);
    chk("floor_best",   32'(best_streak), 32'd3);
    chk("floor_state",  32'(game_state), 32'd3);
    for (int i = 0; i < 14; i++) step(2'd0, 16'd1000, 1'b0, 1'b0);
    chk("drop_idle", 32'(game_state), 32'd0);

    // flight timeout
    step(2'd1, 16'd1000, 1'b0, 1'b0);
    step(2'd0, 16'd1000, 1'b0, 1'b1);
    ticks = 0; ticks_at_drop = 0; seen = 1'b0; prev_ft = '0; ft_before = '0;
    for (int i = 0; i < 40; i++) begin
      step(2'd0, 16'd1000, 1'b0, 1'b0);
      if (!seen) begin
        if (last_tick) ticks++;
        if (drop_event) begin
          seen = 1'b1; ticks_at_drop = ticks; ft_before = prev_ft;
        end
        prev_ft = flight_ticks;
      end
    end
    chk("to_seen",      32'(seen), 32'd1);
    chk("to_ticks",     32'(ticks_at_drop), 32'(FT));
    chk("to_ft_before", 32'(ft_before), 32'(FT - 1));

    // catch coinciding with floor height
    step(2'd2, 16'd1000, 1'b0, 1'b0);
    step(2'd0, 16'd1000, 1'b0, 1'b1);
    step(2'd1, 16'd10,   1'b1, 1'b0);
    chk("cf_pass",  32'(pass_event), 32'd1);
    chk("cf_drop",  32'(drop_event), 32'd0);
    chk("cf_score", 32'(score), 32'd4);

    // respawn without catch, invalid ball_state on the floor
    step(2'd0, 16'd1000, 1'b0, 1'b1);
    step(2'd2, 16'd1000, 1'b0, 1'b0);
    step(2'd0, 16'd1000, 1'b0, 1'b1);
    step(2'd3, 16'd20,   1'b0, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0) ? 16'd30 : 16'd1000,
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0));

    // streak saturation
    do_reset();
    step(2'd1, 16'd1000, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) pass_to((i % 2 == 0) ? 2'd2 : 2'd1);
    chk("sat_streak", 32'(streak), 32'd255);
    chk("sat_best",   32'(best_streak), 32'd255);
    chk("sat_score",  32'(score), 32'd260);

    // score saturation
    force dut.score_q = 16'hFFFE;
    #1;
    release dut.score_q;
    m_score = 16'hFFFE;
    pass_to(2'd2);
    chk("score_ffff", 32'(score), 32'hFFFF);
    pass_to(2'd1);
    chk("score_hold", 32'(score), 32'hFFFF);

    // reset in flight
    step(2'd0, 16'd1000, 1'b0, 1'b1);
    step(2'd0, 16'd1000, 1'b0, 1'b0);
    do_reset();
    chk("rst_drop",  32'(drop_event), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_state", 32'(game_state), 32'd0);
    step(2'd0, 16'd1000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
